// File: rtl/icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_direct: direct-mapped I-cache, one 32-bit word per line, one miss |
// | outstanding. Define ICACHE_STATS_EN to add saturating hit/miss counters. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module icache_direct #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_resp_addr,
    output logic [31:0]           if_instr,
    output logic                  mc_req,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    input  logic                  mc_done,
    input  logic [ADDR_WIDTH-1:0] mc_resp_addr,
`ifdef ICACHE_STATS_EN
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
`endif
    input  logic [31:0]           mc_instr
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic                  r_cancel;
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic                  r_if_valid;
    logic [ADDR_WIDTH-1:0] r_if_resp_addr;
    logic [31:0]           r_if_instr;
    logic                  r_mc_req;
    logic [ADDR_WIDTH-1:0] r_mc_addr;

    logic                  w_cancel_nxt;
    logic [ADDR_WIDTH-1:0] w_miss_addr_nxt;
    logic                  w_if_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_if_resp_addr_nxt;
    logic [31:0]           w_if_instr_nxt;
    logic                  w_mc_req_nxt;
    logic [ADDR_WIDTH-1:0] w_mc_addr_nxt;
    logic                  w_fill_we;
    logic                  w_hit_served;
    logic                  w_miss_start;

    logic [INDEX_BITS-1:0] w_req_idx;
    logic [TAG_BITS-1:0]   w_req_tag;
    logic [INDEX_BITS-1:0] w_miss_idx;
    logic [TAG_BITS-1:0]   w_miss_tag;
    logic                  w_hit;
    logic                  w_fill_match;
    logic                  w_unused_lsb;

    assign w_req_idx    = if_addr[INDEX_BITS+1:2];
    assign w_req_tag    = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_miss_idx   = r_miss_addr[INDEX_BITS+1:2];
    assign w_miss_tag   = r_miss_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit        = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_fill_match = mc_done &&
                          (mc_resp_addr[ADDR_WIDTH-1:2] == r_miss_addr[ADDR_WIDTH-1:2]);
    assign w_unused_lsb = ^mc_resp_addr[1:0];

    always_comb begin
        w_state_nxt        = r_state;
        w_cancel_nxt       = r_cancel;
        w_miss_addr_nxt    = r_miss_addr;
        w_if_valid_nxt     = 1'b0;
        w_if_resp_addr_nxt = r_if_resp_addr;
        w_if_instr_nxt     = r_if_instr;
        w_mc_req_nxt       = r_mc_req;
        w_mc_addr_nxt      = r_mc_addr;
        w_fill_we          = 1'b0;
        w_hit_served       = 1'b0;
        w_miss_start       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The request that produced last cycle's response is still
                // held by IF, so it must not be sampled again.
                if (if_req && !r_if_valid) begin
                    if (w_hit) begin
                        if (!flush) begin
                            w_if_valid_nxt     = 1'b1;
                            w_if_resp_addr_nxt = if_addr;
                            w_if_instr_nxt     = r_data[w_req_idx];
                            w_hit_served       = 1'b1;
                        end
                    end else begin
                        w_state_nxt     = S_FILL;
                        w_miss_addr_nxt = if_addr;
                        w_mc_req_nxt    = 1'b1;
                        w_mc_addr_nxt   = if_addr;
                        w_cancel_nxt    = flush;
                        w_miss_start    = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (w_fill_match) begin
                    // The line is installed even when the response is dropped.
                    w_fill_we    = 1'b1;
                    w_mc_req_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                    w_cancel_nxt = 1'b0;
                    if (!r_cancel && !flush) begin
                        w_if_valid_nxt     = 1'b1;
                        w_if_resp_addr_nxt = r_miss_addr;
                        w_if_instr_nxt     = mc_instr;
                    end
                end else if (flush) begin
                    w_cancel_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_cancel       <= 1'b0;
            r_miss_addr    <= '0;
            r_if_valid     <= 1'b0;
            r_if_resp_addr <= '0;
            r_if_instr     <= '0;
            r_mc_req       <= 1'b0;
            r_mc_addr      <= '0;
        end else if (rdy) begin
            r_state        <= w_state_nxt;
            r_cancel       <= w_cancel_nxt;
            r_miss_addr    <= w_miss_addr_nxt;
            r_if_valid     <= w_if_valid_nxt;
            r_if_resp_addr <= w_if_resp_addr_nxt;
            r_if_instr     <= w_if_instr_nxt;
            r_mc_req       <= w_mc_req_nxt;
            r_mc_addr      <= w_mc_addr_nxt;
            if (w_fill_we) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && w_fill_we) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= mc_instr;
        end
    end

    assign if_valid     = r_if_valid;
    assign if_resp_addr = r_if_resp_addr;
    assign if_instr     = r_if_instr;
    assign mc_req       = r_mc_req;
    assign mc_addr      = r_mc_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (rdy) begin
            if (w_hit_served && (r_stat_hits != 32'hFFFF_FFFF)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
            if (w_miss_start && (r_stat_misses != 32'hFFFF_FFFF)) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_hit_served ^ w_miss_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// Scoreboard bench for icache_direct: stimulus queues expected IF responses and
// the expected mc_req/mc_addr level; a negedge monitor does all comparisons.
module tb_icache_direct;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_resp_addr;
    logic [31:0] if_instr;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_resp_addr;
    logic [31:0] mc_instr;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    resp_t       exp_q[$];
    logic        exp_mc_req;
    logic [31:0] exp_mc_addr;
    logic        end_req;
    int          checks;
    int          failures;
    int          cycle;

    icache_direct dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_valid     (if_valid),
        .if_resp_addr (if_resp_addr),
        .if_instr     (if_instr),
        .mc_req       (mc_req),
        .mc_addr      (mc_addr),
        .mc_done      (mc_done),
        .mc_resp_addr (mc_resp_addr),
`ifdef ICACHE_STATS_EN
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses),
`endif
        .mc_instr     (mc_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every comparison in the bench happens here.
    always @(negedge clk) begin
        resp_t e;
        cycle++;
        if (!rst) begin
            check("reset_outputs", {30'd0, if_valid, mc_req, mc_addr, if_resp_addr, if_instr}, 128'd0);
        end else begin
            check("mc_req", {127'd0, mc_req}, {127'd0, exp_mc_req});
            if (exp_mc_req) begin
                check("mc_addr", {96'd0, mc_addr}, {96'd0, exp_mc_addr});
            end
            if (if_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual addr=%0h instr=%0h required=none",
                             if_resp_addr, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {64'd0, if_resp_addr, if_instr}, {64'd0, e.addr, e.instr});
                end
            end
        end
        if (end_req) begin
            check("pending_resp", 128'(exp_q.size()), 128'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        if (cycle > 4000) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=%0d cycles required=<=4000", cycle);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic miss_start(input logic [31:0] a);
        step();
        if_req  = 1'b1;
        if_addr = a;
        step();
        exp_mc_req  = 1'b1;
        exp_mc_addr = a;
    endtask

    // Completes the outstanding fill; IF holds its request through the
    // response cycle unless no response is expected.
    task automatic fill_done(input logic [31:0] a, input logic [31:0] d,
                             input bit expect_resp, input bit fl);
        step();
        mc_done      = 1'b1;
        mc_resp_addr = a;
        mc_instr     = d;
        flush        = fl;
        if (expect_resp) exp_q.push_back({a, d});
        step();
        mc_done    = 1'b0;
        flush      = 1'b0;
        exp_mc_req = 1'b0;
        if (!expect_resp) if_req = 1'b0;
        step();
        if_req = 1'b0;
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d, input bit fl);
        step();
        if_req  = 1'b1;
        if_addr = a;
        flush   = fl;
        if (!fl) exp_q.push_back({a, d});
        step();
        flush = 1'b0;
        if (fl) if_req = 1'b0;
        step();
        if_req = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        end_req      = 1'b0;
        exp_mc_req   = 1'b0;
        exp_mc_addr  = '0;
        rst          = 1'b1;
        rdy          = 1'b1;
        flush        = 1'b0;
        if_req       = 1'b0;
        if_addr      = '0;
        mc_done      = 1'b0;
        mc_resp_addr = '0;
        mc_instr     = '0;
        #2 rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Cold miss, then hit, then a flushed hit and a normal hit.
        miss_start(32'h0000_0000);
        fill_done(32'h0000_0000, 32'h0000_0513, 1, 0);
        hit(32'h0000_0000, 32'h0000_0513, 0);
        hit(32'h0000_0000, 32'h0000_0513, 1);
        hit(32'h0000_0000, 32'h0000_0513, 0);

        // Conflict eviction at index 0.
        miss_start(32'h0000_0100);
        fill_done(32'h0000_0100, 32'h0010_0093, 1, 0);
        miss_start(32'h0000_0000);
        fill_done(32'h0000_0000, 32'h0000_0513, 1, 0);

        // Flush two cycles after the miss request: installed, no response.
        miss_start(32'h0000_0040);
        step();
        flush = 1'b1;
        step();
        flush  = 1'b0;
        if_req = 1'b0;
        fill_done(32'h0000_0040, 32'h1234_5678, 0, 0);
        step();
        hit(32'h0000_0040, 32'h1234_5678, 0);

        // Flush in the same cycle as the matching fill.
        miss_start(32'h0000_00C0);
        fill_done(32'h0000_00C0, 32'hAABB_CCDD, 0, 1);
        hit(32'h0000_00C0, 32'hAABB_CCDD, 0);

        // Mismatched completion, then rdy low with a would-be completion.
        miss_start(32'h0000_0080);
        step();
        mc_done      = 1'b1;
        mc_resp_addr = 32'h0000_0084;
        mc_instr     = 32'hDEAD_0084;
        step();
        rdy          = 1'b0;
        mc_resp_addr = 32'h0000_0080;
        mc_instr     = 32'hBAD0_0080;
        step();
        step();
        step();
        rdy     = 1'b1;
        mc_done = 1'b0;
        fill_done(32'h0000_0080, 32'h0000_0297, 1, 0);
        miss_start(32'h0000_0084);
        fill_done(32'h0000_0084, 32'h0000_0317, 1, 0);

        // Asynchronous reset in the middle of a fill.
        miss_start(32'h0000_0200);
        #1;
        rst        = 1'b0;
        exp_mc_req = 1'b0;
        step();
        step();
        rst    = 1'b1;
        if_req = 1'b0;
        miss_start(32'h0000_0000);
        fill_done(32'h0000_0000, 32'h0000_0513, 1, 0);

        step();
        step();
        end_req = 1'b1;
        repeat (5) step();
        $display("FAIL summary_not_reached actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
`default_nettype wire
